expr_result_bcd: RTL

Downstream consumer of the math-expression result stage. It captures the signed quotient/remainder pair on that stage's one-cycle valid tick. The captured value is q + rmd/2. The block converts this to sign-magnitude BCD with a half-digit flag, using an iterative double-dabble. The packed result goes to the display and readout logic.

---
 rtl/expr_result_bcd_pkg.sv | 26 ++
 rtl/expr_result_bcd_add3_digit.sv | 10 +
 rtl/expr_result_bcd.sv | 124 ++++++++++++
 3 files changed

// File: rtl/expr_result_bcd_pkg.sv
// Shared definitions for the quotient/remainder to sign-magnitude BCD converter.
// Holds the FSM encoding and the elaboration-time digit-count helper.
package expr_result_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest number of decimal digits d with 10^d > 2^(w-1).
  function automatic int min_digits(input int w);
    longint unsigned lim;
    longint unsigned p;
    int d;
    lim = 64'd1 << (w - 1);
    p = 64'd1;
    d = 0;
    while (p <= lim) begin
      p = p * 64'd10;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/expr_result_bcd_add3_digit.sv
// Double-dabble digit correction: d+3 when d>=5, else d. Purely combinational,
// zero latency, no flow control.
module bcd_add3_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/expr_result_bcd.sv
// Captures signed q + rmd/2 and converts it to sign-magnitude BCD with a half flag.
// Result W+1 cycles after the in_valid cycle; samples arriving while busy are dropped and flagged in overrun.
module expr_result_bcd
  import expr_result_bcd_pkg::*;
#(
  parameter int W      = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [W-1:0]          in_q,
  input  logic                  in_rmd,
  output logic                  busy,
  output logic                  out_valid,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  half,
  output logic                  overrun
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int BW = 4 * DIGITS;

  if (DIGITS < min_digits(W)) begin : g_digits_check
    $error("expr_result_bcd: DIGITS too small to hold 2^(W-1)");
  end

  state_t          state;
  state_t          state_next;
  logic [W-1:0]    mag_work;
  logic [BW-1:0]   bcd_work;
  logic            neg_work;
  logic            half_work;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic [W-1:0]    q_abs;
  logic [W-1:0]    cap_mag;
  logic            cap_neg;
  logic            cap_half;
  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_next;
  logic [W-1:0]    mag_next;

  assign busy      = (state == CONV);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && ((state == IDLE) || (state == DONE));

  // Sign-magnitude fold: a negative value with a half bit is -(|q|-1) - 0.5.
  assign q_abs = ~in_q + W'(1);

  always_comb begin
    cap_half = in_rmd;
    cap_mag  = in_q;
    if (in_q[W-1]) begin
      cap_mag = in_rmd ? q_abs - W'(1) : q_abs;
    end
    cap_neg = in_q[W-1] && ((cap_mag != '0) || cap_half);
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3_digit u_add3 (
      .d (bcd_work[4*i +: 4]),
      .q (bcd_adj[4*i +: 4])
    );
  end

  assign {bcd_next, mag_next} = {bcd_adj, mag_work} << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CONV;
      CONV:    if (cnt == '0) state_next = DONE;
      DONE:    state_next = in_valid ? CONV : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_work  <= '0;
      bcd_work  <= '0;
      neg_work  <= 1'b0;
      half_work <= 1'b0;
      cnt       <= '0;
      neg       <= 1'b0;
      bcd       <= '0;
      half      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        mag_work  <= cap_mag;
        bcd_work  <= '0;
        neg_work  <= cap_neg;
        half_work <= cap_half;
        cnt       <= CW'(W - 1);
      end else if (state == CONV) begin
        mag_work <= mag_next;
        bcd_work <= bcd_next;
        cnt      <= cnt - CW'(1);
        // Final iteration: publish straight from the shift result.
        if (cnt == '0) begin
          bcd  <= bcd_next;
          neg  <= neg_work;
          half <= half_work;
        end
      end
      if ((state == CONV) && in_valid) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
